mag_timer: RTL and testbench

- Countdown timer for the microwave controller, directly upstream of the magnetron on/off control stage.
- Holds the cooking time as four BCD digits (MM:SS) entered from the keypad, and decrements it once per second while the magnetron is on.
- Drives time_over, which the on/off control stage consumes to reset the magnetron latch.

---
 rtl/mag_pkg.sv | 21 ++
 rtl/bcd_digit_dec.sv | 23 ++
 rtl/mag_timer.sv | 140 ++++++++++++++
 tb/tb_mag_timer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mag_pkg.sv
// Shared encodings and BCD constants for the microwave cooking-time countdown.
package mag_pkg;

    localparam logic [1:0] ST_ENTRY  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    localparam logic [3:0] BCD_NINE     = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    typedef enum logic [1:0] {
        StEntry  = ST_ENTRY,
        StRun    = ST_RUN,
        StPaused = ST_PAUSED
    } mag_state_e;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One stage of the BCD borrow chain: decrement on borrow-in, wrap from 0 to i_wrap.
module bcd_digit_dec (
    input  logic [3:0] i_digit,
    input  logic       i_borrow_in,
    input  logic [3:0] i_wrap,
    output logic [3:0] o_digit,
    output logic       o_borrow_out
);

    always_comb begin
        o_digit      = i_digit;
        o_borrow_out = 1'b0;
        if (i_borrow_in) begin
            if (i_digit == 4'd0) begin
                o_digit      = i_wrap;
                o_borrow_out = 1'b1;
            end else begin
                o_digit = i_digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/mag_timer.sv
// MM:SS countdown timer: keypad entry, one-second decrement while heating, time_over/done flags.
module mag_timer
    import mag_pkg::*;
#(
    parameter int unsigned DIV = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_key_valid,
    input  logic [3:0] i_key_digit,
    input  logic       i_nclear,
    input  logic       i_mag_on,
    output logic [3:0] o_min_tens,
    output logic [3:0] o_min_units,
    output logic [3:0] o_sec_tens,
    output logic [3:0] o_sec_units,
    output logic       o_time_over,
    output logic       o_done
);

    localparam int unsigned     PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);

    mag_state_e    r_state, w_state_d;
    logic [15:0]   r_digits, w_digits_d;
    logic [PW-1:0] r_presc, w_presc_d;
    logic          r_time_over, w_time_over_d;
    logic          r_done, w_done_d;

    logic [15:0]   w_dec;
    logic          w_b_su, w_b_st, w_b_mu, w_b_mt;

    // Borrow chain; r_digits is {mt, mu, st, su}
    bcd_digit_dec u_dec_su (
        .i_digit      (r_digits[3:0]),
        .i_borrow_in  (1'b1),
        .i_wrap       (BCD_NINE),
        .o_digit      (w_dec[3:0]),
        .o_borrow_out (w_b_su)
    );

    bcd_digit_dec u_dec_st (
        .i_digit      (r_digits[7:4]),
        .i_borrow_in  (w_b_su),
        .i_wrap       (SEC_TENS_MAX),
        .o_digit      (w_dec[7:4]),
        .o_borrow_out (w_b_st)
    );

    bcd_digit_dec u_dec_mu (
        .i_digit      (r_digits[11:8]),
        .i_borrow_in  (w_b_st),
        .i_wrap       (BCD_NINE),
        .o_digit      (w_dec[11:8]),
        .o_borrow_out (w_b_mu)
    );

    bcd_digit_dec u_dec_mt (
        .i_digit      (r_digits[15:12]),
        .i_borrow_in  (w_b_mu),
        .i_wrap       (BCD_NINE),
        .o_digit      (w_dec[15:12]),
        .o_borrow_out (w_b_mt)
    );

    always_comb begin
        w_state_d  = r_state;
        w_digits_d = r_digits;
        w_presc_d  = r_presc;
        w_done_d   = 1'b0;

        if (!i_nclear) begin
            w_digits_d = 16'd0;
            w_presc_d  = '0;
            w_state_d  = StEntry;
        end else begin
            unique case (r_state)
                StEntry: begin
                    if (i_mag_on && (r_digits != 16'd0)) begin
                        w_state_d = StRun;
                        w_presc_d = '0;
                    end else if (i_key_valid && bcd_valid(i_key_digit)) begin
                        w_digits_d = {r_digits[11:0], i_key_digit};
                    end
                end
                StRun: begin
                    if (!i_mag_on) begin
                        w_state_d = StPaused;
                    end else if (r_presc == PRESC_MAX) begin
                        w_presc_d = '0;
                        // A borrow out of mt would mean a zero count; never decrement past 00:00
                        if (!w_b_mt) begin
                            w_digits_d = w_dec;
                            if (w_dec == 16'd0) begin
                                w_done_d  = 1'b1;
                                w_state_d = StEntry;
                            end
                        end
                    end else begin
                        w_presc_d = r_presc + 1'b1;
                    end
                end
                StPaused: begin
                    if (i_mag_on) begin
                        w_state_d = StRun;
                    end
                end
                default: begin
                    w_state_d = StEntry;
                end
            endcase
        end

        w_time_over_d = (w_digits_d == 16'd0);
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_state     <= StEntry;
            r_digits    <= 16'd0;
            r_presc     <= '0;
            r_time_over <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_digits    <= w_digits_d;
            r_presc     <= w_presc_d;
            r_time_over <= w_time_over_d;
            r_done      <= w_done_d;
        end
    end

    assign o_min_tens  = r_digits[15:12];
    assign o_min_units = r_digits[11:8];
    assign o_sec_tens  = r_digits[7:4];
    assign o_sec_units = r_digits[3:0];
    assign o_time_over = r_time_over;
    assign o_done      = r_done;

endmodule

// File: tb/tb_mag_timer.sv
// Directed bench for mag_timer with a 4-cycle prescaler.
module tb_mag_timer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       nclear;
    logic       mag_on;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       time_over;
    logic       done;

    int total = 0;
    int bad   = 0;

    mag_timer #(
        .DIV (4)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_key_valid (key_valid),
        .i_key_digit (key_digit),
        .i_nclear    (nclear),
        .i_mag_on    (mag_on),
        .o_min_tens  (min_tens),
        .o_min_units (min_units),
        .o_sec_tens  (sec_tens),
        .o_sec_units (sec_units),
        .o_time_over (time_over),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] disp();
        return {min_tens, min_units, sec_tens, sec_units};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic clear_pulse();
        nclear = 1'b0;
        step(1);
        nclear = 1'b1;
    endtask

    int done_cnt;
    int done_at;

    initial begin
        nrst      = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        nclear    = 1'b1;
        mag_on    = 1'b0;
        step(1);
        chk("reset_digits", disp(), 16'h0000);
        chk("reset_time_over", {15'd0, time_over}, 16'd1);
        chk("reset_done", {15'd0, done}, 16'd0);
        nrst = 1'b1;

        // Entry
        key(4'd1);
        key(4'd2);
        key(4'd3);
        chk("entry_123", disp(), 16'h0123);
        chk("entry_time_over", {15'd0, time_over}, 16'd0);
        key(4'd12);
        chk("entry_key12_ignored", disp(), 16'h0123);
        key(4'd15);
        chk("entry_key15_ignored", disp(), 16'h0123);

        // Countdown 01:00 -> 00:00 with borrow through every stage
        clear_pulse();
        chk("clear_to_zero", disp(), 16'h0000);
        key(4'd1);
        key(4'd0);
        key(4'd0);
        chk("load_0100", disp(), 16'h0100);
        mag_on = 1'b1;
        step(1);                      // ENTRY -> RUN, prescaler 0
        step(3);
        chk("run_before_tick", disp(), 16'h0100);
        step(1);
        chk("run_first_dec", disp(), 16'h0059);
        chk("run_time_over_low", {15'd0, time_over}, 16'd0);
        done_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 236; i++) begin
            step(1);
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
            end
        end
        chk("run_end_digits", disp(), 16'h0000);
        chk("run_end_time_over", {15'd0, time_over}, 16'd1);
        chk("run_done_count", 16'(done_cnt), 16'd1);
        chk("run_done_last_edge", 16'(done_at), 16'd235);
        step(1);
        chk("run_done_one_cycle", {15'd0, done}, 16'd0);
        chk("run_stays_zero", disp(), 16'h0000);
        mag_on = 1'b0;

        // Pause and resume: prescaler is kept across the pause
        key(4'd5);
        chk("load_0005", disp(), 16'h0005);
        mag_on = 1'b1;
        step(7);                      // RUN entry, tick at 5th edge, prescaler ends at 2
        chk("pause_first_dec", disp(), 16'h0004);
        mag_on = 1'b0;
        step(10);
        chk("pause_hold", disp(), 16'h0004);
        mag_on = 1'b1;
        step(1);                      // PAUSED -> RUN
        chk("resume_edge", disp(), 16'h0004);
        step(1);
        chk("resume_presc3", disp(), 16'h0004);
        step(1);
        chk("resume_dec", disp(), 16'h0003);
        mag_on = 1'b0;
        step(3);
        chk("paused_0003", disp(), 16'h0003);

        // Clear from PAUSED
        clear_pulse();
        chk("clear_paused", disp(), 16'h0000);
        chk("clear_time_over", {15'd0, time_over}, 16'd1);
        key(4'd4);
        chk("key_after_clear", disp(), 16'h0004);

        // Start with zero count
        clear_pulse();
        mag_on   = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (done === 1'b1) done_cnt++;
            if (time_over !== 1'b1) done_cnt += 100;
        end
        chk("zero_start_no_done", 16'(done_cnt), 16'd0);
        chk("zero_start_digits", disp(), 16'h0000);
        mag_on = 1'b0;
        key(4'd7);
        chk("zero_start_entry", disp(), 16'h0007);

        // Keyed sec_tens above 5 counts down as plain BCD
        clear_pulse();
        key(4'd7);
        key(4'd0);
        mag_on = 1'b1;
        step(5);
        chk("sec_tens_70_dec", disp(), 16'h0069);
        mag_on = 1'b0;
        step(1);

        // Keys during RUN, then reset mid-RUN
        clear_pulse();
        key(4'd4);
        key(4'd0);
        chk("load_0040", disp(), 16'h0040);
        mag_on = 1'b1;
        step(1);
        key(4'd9);
        key(4'd8);
        chk("run_keys_ignored", disp(), 16'h0040);
        nrst = 1'b0;
        step(1);
        chk("mid_run_reset_digits", disp(), 16'h0000);
        chk("mid_run_reset_time_over", {15'd0, time_over}, 16'd1);
        nrst   = 1'b1;
        mag_on = 1'b0;
        key(4'd2);
        chk("entry_after_reset", disp(), 16'h0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
